mdu_ctrl: RTL and testbench

Iterative multiply/divide sequencer for the HI/LO datapath. It takes a mult/multu/div/divu from EX, runs a shift-add or restoring-divide loop one bit per cycle, and holds the pipeline via a stall request until done. The 64-bit {hi,lo} result and a one-cycle valid feed the div_mul_result field carried through MEM/WB to the HI/LO write path.

---
 rtl/mdu_ctrl.sv | 149 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide sequencer for the HI/LO datapath.
// One bit per cycle shift-add multiply and restoring divide. stallreq holds EX
// while the loop runs. result_valid pulses for the single DONE cycle.
module mdu_ctrl #(
  parameter bit MUL_FAST = 1'b0  // 1: multiply completes in one cycle (IDLE->DONE)
) (
  input  logic        clk,
  input  logic        rst,           // asynchronous, active-low
  input  logic        start,
  input  logic [1:0]  op,            // 00 mult, 01 multu, 10 div, 11 divu
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        annul,
  output logic        stallreq,
  output logic        result_valid,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [31:0] hi, lo;         // {rem,quot} for divide, {acc_hi,multiplier} for multiply
  logic [31:0] opnd;           // divisor for divide, multiplicand for multiply
  logic [31:0] a_raw;          // dividend as given, needed for the divide-by-zero result
  logic        is_div, sign_q, sign_r, div_zero;
  logic [63:0] result_hold;

  logic        op_signed, op_div, fast_mul, accept;
  logic [31:0] abs_a, abs_b;
  logic [32:0] rem_sh, diff, add;
  logic [63:0] corrected;

  // Operand decode: magnitudes only taken for signed ops with a negative operand.
  always_comb begin
    op_signed = ~op[0];
    op_div    = op[1];
    abs_a     = (op_signed && src_a[31]) ? -src_a : src_a;
    abs_b     = (op_signed && src_b[31]) ? -src_b : src_b;
    fast_mul  = MUL_FAST && !op_div;
    accept    = (state == IDLE) && start && !annul;
  end

  // One iteration of each algorithm: trial subtract for divide, conditional add for multiply.
  always_comb begin
    rem_sh = {hi, lo[31]};
    diff   = rem_sh - {1'b0, opnd};
    add    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
  end

  // Sign fix-up of the finished magnitude result; divide by zero bypasses it.
  always_comb begin
    corrected = {hi, lo};
    if (div_zero)
      corrected = {a_raw, 32'hFFFF_FFFF};
    else if (is_div)
      corrected = {(sign_r ? -hi : hi), (sign_q ? -lo : lo)};
    else if (sign_q)
      corrected = -{hi, lo};
  end

  // Next-state and stall request; annul overrides everything.
  always_comb begin
    state_next = state;
    stallreq   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = fast_mul ? DONE : RUN;
          stallreq   = !fast_mul;
        end
      end
      RUN: begin
        stallreq = 1'b1;
        if (count == 5'd31) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (annul) begin
      state_next = IDLE;
      stallreq   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Working registers: load on accept, iterate while running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= 5'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      opnd     <= 32'd0;
      a_raw    <= 32'd0;
      is_div   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      count    <= 5'd0;
      a_raw    <= src_a;
      is_div   <= op_div;
      sign_q   <= op_signed && (src_a[31] ^ src_b[31]);
      sign_r   <= op_signed && op_div && src_a[31];
      div_zero <= op_div && (src_b == 32'd0);
      if (op_div) begin
        hi   <= 32'd0;
        lo   <= abs_a;
        opnd <= abs_b;
      end else if (MUL_FAST) begin
        {hi, lo} <= {32'd0, abs_a} * {32'd0, abs_b};
        opnd     <= abs_a;
      end else begin
        hi   <= 32'd0;
        lo   <= abs_b;
        opnd <= abs_a;
      end
    end else if (state == RUN) begin
      count <= count + 5'd1;
      if (is_div) begin
        hi <= diff[32] ? rem_sh[31:0] : diff[31:0];
        lo <= {lo[30:0], ~diff[32]};
      end else begin
        hi <= add[32:1];
        lo <= {add[0], lo[31:1]};
      end
    end
  end

  // Result register only changes on a DONE that was not annulled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      result_hold <= 64'd0;
    else if (state == DONE && !annul)
      result_hold <= corrected;
  end

  // During the valid cycle the finished value is already visible on result.
  always_comb begin
    result_valid = (state == DONE) && !annul;
    result       = result_valid ? corrected : result_hold;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: random and directed ops on an iterative and a MUL_FAST instance,
// checked against an arithmetic reference model.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, annul;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, result_valid;
  logic [63:0] result;

  logic        start_f, annul_f;
  logic [1:0]  op_f;
  logic [31:0] src_a_f, src_b_f;
  logic        stallreq_f, result_valid_f;
  logic [63:0] result_f;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;
  int last_valid_cyc = 0;
  logic [63:0] last_exp = 64'd0;

  mdu_ctrl #(.MUL_FAST(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .annul(annul), .stallreq(stallreq), .result_valid(result_valid), .result(result)
  );

  mdu_ctrl #(.MUL_FAST(1'b1)) dut_fast (
    .clk(clk), .rst(rst), .start(start_f), .op(op_f), .src_a(src_a_f), .src_b(src_b_f),
    .annul(annul_f), .stallreq(stallreq_f), .result_valid(result_valid_f), .result(result_f)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: plain 64-bit arithmetic, truncating signed division.
  function automatic logic [63:0] ref_mdu(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p  = 64'd0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Iterative op: start seen at cycle 0, stall cycles 0..32, valid at cycle 33.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    int cyc = 0;
    int stalls = 0;
    bit got = 0;
    logic [63:0] exp;
    exp = ref_mdu(o, a, b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    while (!got && cyc < 100) begin
      if (result_valid) got = 1;
      else begin
        if (stallreq) stalls++;
        @(negedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_valid"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'd33);
    check({tag, "_stalls"}, 64'(stalls), 64'd33);
    check({tag, "_stall_done"}, 64'(stallreq), 64'd0);
    check({tag, "_result"}, result, exp);
    $display("op=%0d a=%h b=%h result=%h exp=%h lat=%0d", o, a, b, result, exp, cyc);
    last_exp = exp;
    last_valid_cyc = cyc_cnt;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, "_pulse_end"}, 64'(result_valid), 64'd0);
  endtask

  // MUL_FAST multiply: no stall at T, valid at T+1.
  task automatic do_op_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
    logic [63:0] exp;
    exp = ref_mdu(o, a, b);
    start_f = 1'b1; op_f = o; src_a_f = a; src_b_f = b;
    #1;
    check({tag, "_stall_T"}, 64'(stallreq_f), 64'd0);
    @(negedge clk);
    start_f = 1'b0;
    #1;
    check({tag, "_valid_T1"}, 64'(result_valid_f), 64'd1);
    check({tag, "_result"}, result_f, exp);
    $display("fast op=%0d a=%h b=%h result=%h exp=%h", o, a, b, result_f, exp);
    @(negedge clk); #1;
    check({tag, "_pulse_end"}, 64'(result_valid_f), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int v1, sel;

    rst = 1'b0; start = 1'b0; annul = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    start_f = 1'b0; annul_f = 1'b0; op_f = 2'b00; src_a_f = 32'd0; src_b_f = 32'd0;
    @(negedge clk); #1;
    check("rst_stall", 64'(stallreq), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_fast_result", result_f, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases
    do_op(2'b11, 32'd100, 32'd7, "divu_100_7");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    do_op(2'b00, 32'hFFFF_FFFF, 32'd2, "mult_m1_2");
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, "multu_ff_2");
    do_op(2'b11, 32'h1234_5678, 32'd0, "divu_by0");
    do_op(2'b10, 32'h8765_4321, 32'd0, "div_by0");
    do_op_fast(2'b00, 32'hFFFF_FFFF, 32'd2, "fmult_m1_2");
    do_op_fast(2'b01, 32'hFFFF_FFFF, 32'd2, "fmultu_ff_2");

    // Annul at RUN counter=10 (cycle T+11)
    start = 1'b1; op = 2'b11; src_a = 32'd5000; src_b = 32'd3;
    repeat (11) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    #1;
    check("annul_stall", 64'(stallreq), 64'd0);
    check("annul_valid", 64'(result_valid), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    #1;
    check("annul_idle_stall", 64'(stallreq), 64'd0);
    check("annul_idle_valid", 64'(result_valid), 64'd0);
    check("annul_result_kept", result, last_exp);
    do_op(2'b11, 32'd5000, 32'd3, "divu_after_annul");

    // Asynchronous reset mid-RUN, checked between clock edges
    start = 1'b1; op = 2'b01; src_a = 32'h0ABC_DEF0; src_b = 32'h1357_9BDF;
    repeat (5) @(negedge clk);
    start = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("arst_stall", 64'(stallreq), 64'd0);
    check("arst_valid", 64'(result_valid), 64'd0);
    check("arst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_idle_stall", 64'(stallreq), 64'd0);
    do_op(2'b01, 32'h0ABC_DEF0, 32'h1357_9BDF, "multu_after_rst");

    // Back-to-back multiplies: DONE at T+33, next accept at T+34, next DONE 34 later
    do_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, "b2b_mult1");
    v1 = last_valid_cyc;
    do_op(2'b00, 32'hDEAD_BEEF, 32'h0000_1234, "b2b_mult2");
    check("b2b_gap", 64'(last_valid_cyc - v1), 64'd34);

    // Random ops, biased toward the corner cases
    for (int i = 0; i < 14; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (sel == 2) rb = 32'($urandom_range(1, 15));
      do_op(ro, ra, rb, $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      do_op_fast(ro, ra, rb, $sformatf("frnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
